// File: rtl/instruction_loader.sv
// instruction_loader: fills the fetch-stage instruction memory from a UART byte
// stream. Four bytes (little-endian) form one 32-bit word, which is written at
// consecutive word-aligned byte addresses. The pipeline is held halted while
// loading. Loading ends on the halt word or when the last memory word is written.
module instruction_loader #(
  parameter int unsigned INST_MEM_ADDR_WIDTH = 9,
  parameter logic [31:0] HALT_INSTRUCTION    = 32'hFFFFFFFF
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start_load,
  input  logic [7:0]                     i_rx_data,
  input  logic                           i_rx_valid,
  output logic                           o_write_instruction_flag,
  output logic [INST_MEM_ADDR_WIDTH-1:0] o_address_to_write_inst,
  output logic [31:0]                    o_instruction_to_write,
  output logic                           o_cpu_halt,
  output logic                           o_busy,
  output logic                           o_load_done,
  output logic                           o_mem_full
);

  // Byte address of the last word in memory; reaching it ends the load.
  localparam logic [INST_MEM_ADDR_WIDTH-1:0] LAST_ADDR =
    {{(INST_MEM_ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [INST_MEM_ADDR_WIDTH-1:0] ADDR_STEP =
    INST_MEM_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                           state_q;
  logic [INST_MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]                       byte_cnt_q;
  logic [31:0]                      word_q;
  logic                             write_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             mem_full_q;

  // Load sequencer: state, counters, assembly register and registered flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_full_q <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start_load) begin
            state_q    <= S_RECEIVE;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            mem_full_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RECEIVE: begin
          if (i_rx_valid) begin
            case (byte_cnt_q)
              2'd0:    word_q[7:0]   <= i_rx_data;
              2'd1:    word_q[15:8]  <= i_rx_data;
              2'd2:    word_q[23:16] <= i_rx_data;
              default: word_q[31:24] <= i_rx_data;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= S_WRITE;
              write_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Halt check has priority; the full check precedes the increment
          // so the address never wraps.
          if (word_q == HALT_INSTRUCTION) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            mem_full_q <= 1'b1;
          end else begin
            addr_q  <= addr_q + ADDR_STEP;
            state_q <= S_RECEIVE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_write_instruction_flag = write_q;
  assign o_address_to_write_inst  = addr_q;
  assign o_instruction_to_write   = word_q;
  assign o_cpu_halt               = busy_q;
  assign o_busy                   = busy_q;
  assign o_load_done              = done_q;
  assign o_mem_full               = mem_full_q;

endmodule
